icosoc_mod_ping_resp: RTL and testbench
=======================================

// Module: icosoc_mod_ping_resp
// PURPOSE
//  Emulates an HC-SR04-style ultrasonic ranger (the responder end of the ping TRIG/ECHO protocol).
//  It watches the TRIG pin and, after a valid trigger, drives an ECHO pulse whose width encodes a
//  CPU-programmed distance in cm. It sits on the icosoc ctrl bus, so sensor-driver firmware and the
//  ping controller can be exercised in hardware loopback without a physical sensor.
// PARAMETERS
//  CLOCK_FREQ_HZ      20000000  informational only; cycle parameters below are sized for 20 MHz
//  CYCLES_PER_CM      1160      ECHO high time per cm of distance, in clk cycles
//  MIN_TRIG_CYCLES    200       minimum TRIG high width accepted as a valid trigger
//  ECHO_DELAY_CYCLES  9000      gap from TRIG fall to ECHO rise (>=1)
//  HOLDOFF_CYCLES     20000     dead time after a measurement; TRIG is ignored during it
// PORTS
//  clk        in   1   system clock
//  resetn     in   1   reset, synchronous, active-low
//  ctrl_wr    in   4   byte write strobes; any nonzero value is a write
//  ctrl_rd    in   1   read strobe
//  ctrl_addr  in   16  register byte address
//  ctrl_wdat  in   32  write data
//  ctrl_rdat  out  32  read data, valid while ctrl_done=1
//  ctrl_done  out  1   one-cycle access acknowledge
//  TRIG       in   1   trigger from the ping initiator (asynchronous)
//  ECHO       out  1   echo pulse to the initiator, registered
// BEHAVIOUR
//  Reset values: ECHO=0, ctrl_done=0, ctrl_rdat=0, state=IDLE, dist=8'hFF, short_err=0, trig_cnt=0.
//  Reset mid-operation: ECHO drops on the reset edge, FSM returns to IDLE, no echo resumes.
//  Bus: an access with ctrl_wr!=0 or ctrl_rd=1 while ctrl_done=0 gives ctrl_done=1 for exactly one
//   cycle on the next edge. ctrl_rdat is registered on that same edge; unmapped reads return 0.
//  Registers:
//   0x00 RW  [7:0] dist, in cm. 255 means no target, so no ECHO pulse. 0 is treated as 1.
//   0x04 R   [0] busy (state!=IDLE), [1] short_err (sticky), [2] ECHO.
//        W   writing 1 to bit1 clears short_err. If a short trigger is detected in the same cycle, set wins.
//   0x08 R   [15:0] trig_cnt (present only with PING_RESP_TRIGCNT_EN; otherwise reads 0).
//  TRIG input: passes through a 2-flop synchronizer (t1, t2); the FSM uses t2 only.
//  FSM states, with a 32-bit counter cnt, a cm sub-counter sub, and a cm counter cms:
//   IDLE    : t2=1 -> TRIG_HI, cnt=1. If TRIG is already high on leaving HOLDOFF, it must go low
//             first (rising-edge qualified, via a t2_d flop).
//   TRIG_HI : t2=1 -> cnt++ (saturating).
//             t2=0 and cnt>=MIN_TRIG_CYCLES -> latch dist_lat=dist, cnt=0, enter DELAY.
//             t2=0 and cnt<MIN_TRIG_CYCLES -> set short_err, go to IDLE.
//   DELAY   : cnt++. When cnt==ECHO_DELAY_CYCLES-1:
//             dist_lat==255 -> HOLDOFF with cnt=0.
//             otherwise -> ECHO=1, sub=0, cms=0, enter PULSE.
//   PULSE   : ECHO held 1. sub wraps at CYCLES_PER_CM-1, and cms increments on each wrap.
//             On the wrap where cms+1==max(dist_lat,1) -> ECHO=0, cnt=0, enter HOLDOFF.
//             ECHO is therefore high exactly max(dist_lat,1)*CYCLES_PER_CM cycles. No multiplier is used.
//   HOLDOFF : cnt++. At HOLDOFF_CYCLES-1 -> IDLE.
//  TRIG activity in DELAY, PULSE or HOLDOFF is ignored (no error, no count).
//  Writes to dist mid-measurement affect the next measurement only.
//  Latency: for the first clk edge that samples TRIG=0, call it edge 0. ECHO rises on edge
//   ECHO_DELAY_CYCLES+2.
// CONFIGURATION
//  PING_RESP_TRIGCNT_EN defined:
//   16-bit trig_cnt increments (wrapping 0xFFFF->0) on each valid trigger (TRIG_HI->DELAY).
//   Readable at 0x08; any write to 0x08 clears it.
//  PING_RESP_TRIGCNT_EN undefined: the counter is not built; 0x08 reads 0 and writes are ignored.
// TESTING
//  T1 reset: resetn=0 for 2 cycles -> ECHO=0; read 0x00=0x000000FF; read 0x04=0.
//  T2 nominal: write 0x00=10; TRIG high 220 cycles -> ECHO rises 9002 edges after TRIG falls and
//     stays high exactly 11600 cycles; busy=1 until 20000 cycles after ECHO falls.
//  T3 short trigger: TRIG high 150 cycles -> no ECHO, 0x04 bit1=1; write 0x04=2 -> bit1=0.
//  T4 no target: dist=255 with a valid trigger -> ECHO stays 0; busy for 9000+20000 cycles.
//     dist=0 -> ECHO high for 1160 cycles.
//  T5 overlap: with dist=5, trigger; during PULSE write dist=3 and pulse TRIG 300 cycles ->
//     width is still 5800 and that TRIG is ignored; the next trigger gives width 3480.
//     With TRIGCNT_EN the count is 2.
//  T6 reset mid-echo: resetn=0 at 1000 cycles into PULSE -> ECHO=0 after the edge; dist=0xFF.

Source files
------------

// File: rtl/icosoc_mod_ping_resp_if.sv
// icosoc ctrl bus bundle for the ping responder: byte write strobes, read strobe and a
// one-cycle done acknowledge with registered read data.
interface icosoc_mod_ping_resp_if;
  logic [3:0]  ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (
    output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    input  ctrl_rdat, ctrl_done
  );

  modport slave (
    input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    output ctrl_rdat, ctrl_done
  );
endinterface

// File: rtl/icosoc_mod_ping_resp.sv
// HC-SR04-style ping responder on the icosoc ctrl bus: qualifies TRIG, then drives an ECHO pulse
// of dist*CYCLES_PER_CM cycles. Define PING_RESP_TRIGCNT_EN to build the trigger counter at 0x08.
module icosoc_mod_ping_resp #(
  parameter int unsigned CLOCK_FREQ_HZ     = 32'd20000000,
  parameter int unsigned CYCLES_PER_CM     = 32'd1160,
  parameter int unsigned MIN_TRIG_CYCLES   = 32'd200,
  parameter int unsigned ECHO_DELAY_CYCLES = 32'd9000,
  parameter int unsigned HOLDOFF_CYCLES    = 32'd20000
) (
  input  logic                  clk,
  input  logic                  resetn,
  icosoc_mod_ping_resp_if.slave ctrl,
  input  logic                  TRIG,
  output logic                  ECHO
);

  localparam logic [31:0] MIN_TRIG   = 32'(MIN_TRIG_CYCLES);
  localparam logic [31:0] DELAY_LAST = 32'(ECHO_DELAY_CYCLES - 32'd1);
  localparam logic [31:0] SUB_LAST   = 32'(CYCLES_PER_CM - 32'd1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG_HI = 3'd1,
    S_DELAY   = 3'd2,
    S_PULSE   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_t1;
  logic        r_t2;
  logic        r_t2_d;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [31:0] r_sub;
  logic [31:0] w_sub_nxt;
  logic [7:0]  r_cms;
  logic [7:0]  w_cms_nxt;
  logic        r_echo;
  logic        w_echo_nxt;
  logic [7:0]  r_dist;
  logic [7:0]  r_dist_lat;
  logic [7:0]  w_dist_lat_nxt;
  logic [7:0]  w_dist_eff;
  logic        r_short_err;
  logic        w_short_set;
  logic        w_trig_ok;
  logic        w_busy;
  logic        r_done;
  logic [31:0] r_rdat;
  logic [31:0] w_rdata;
  logic        w_acc;
  logic        w_wr_acc;
  logic        w_rd_acc;
  logic [15:0] w_trig_cnt;
  logic        w_unused;

  assign w_acc      = ((|ctrl.ctrl_wr) || ctrl.ctrl_rd) && !r_done;
  assign w_wr_acc   = (|ctrl.ctrl_wr) && !r_done;
  assign w_rd_acc   = ctrl.ctrl_rd && !r_done;
  assign w_busy     = (r_state != S_IDLE);
  assign w_dist_eff = (r_dist_lat == 8'd0) ? 8'd1 : r_dist_lat;
  assign w_unused   = &{1'b0, ctrl.ctrl_wdat[31:8], (CLOCK_FREQ_HZ != 32'd0)};

  // TRIG synchronizer plus delayed copy for rising-edge qualification
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_t1   <= 1'b0;
      r_t2   <= 1'b0;
      r_t2_d <= 1'b0;
    end else begin
      r_t1   <= TRIG;
      r_t2   <= r_t1;
      r_t2_d <= r_t2;
    end
  end

  // Ranging sequence next-state and datapath decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sub_nxt      = r_sub;
    w_cms_nxt      = r_cms;
    w_echo_nxt     = r_echo;
    w_dist_lat_nxt = r_dist_lat;
    w_short_set    = 1'b0;
    w_trig_ok      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_t2 && !r_t2_d) begin
          w_state_nxt = S_TRIG_HI;
          w_cnt_nxt   = 32'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TRIG_HI: begin
        if (r_t2) begin
          if (r_cnt != 32'hFFFF_FFFF) begin
            w_cnt_nxt = r_cnt + 32'd1;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end else if (r_cnt >= MIN_TRIG) begin
          w_dist_lat_nxt = r_dist;
          w_cnt_nxt      = 32'd0;
          w_state_nxt    = S_DELAY;
          w_trig_ok      = 1'b1;
        end else begin
          w_short_set = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DELAY: begin
        if (r_cnt != DELAY_LAST) begin
          w_cnt_nxt = r_cnt + 32'd1;
        end else if (r_dist_lat == 8'hFF) begin
          w_cnt_nxt   = 32'd0;
          w_state_nxt = S_HOLDOFF;
        end else begin
          w_echo_nxt  = 1'b1;
          w_sub_nxt   = 32'd0;
          w_cms_nxt   = 8'd0;
          w_state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        // Width is built as dist whole-cm periods, so no multiplier is needed
        if (r_sub != SUB_LAST) begin
          w_sub_nxt = r_sub + 32'd1;
        end else begin
          w_sub_nxt = 32'd0;
          w_cms_nxt = r_cms + 8'd1;
          if (({1'b0, r_cms} + 9'd1) == {1'b0, w_dist_eff}) begin
            w_echo_nxt  = 1'b0;
            w_cnt_nxt   = 32'd0;
            w_state_nxt = S_HOLDOFF;
          end else begin
            w_state_nxt = S_PULSE;
          end
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_echo_nxt  = 1'b0;
      end
    endcase
  end

  // Ranging sequence state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 32'd0;
      r_sub      <= 32'd0;
      r_cms      <= 8'd0;
      r_echo     <= 1'b0;
      r_dist_lat <= 8'hFF;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sub      <= w_sub_nxt;
      r_cms      <= w_cms_nxt;
      r_echo     <= w_echo_nxt;
      r_dist_lat <= w_dist_lat_nxt;
    end
  end

  // Sticky short-trigger flag; a simultaneous set beats the software clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_short_err <= 1'b0;
    end else if (w_short_set) begin
      r_short_err <= 1'b1;
    end else if (w_wr_acc && (ctrl.ctrl_addr == 16'h0004) && ctrl.ctrl_wdat[1]) begin
      r_short_err <= 1'b0;
    end else begin
      r_short_err <= r_short_err;
    end
  end

`ifdef PING_RESP_TRIGCNT_EN
  logic [15:0] r_trig_cnt;

  // Valid-trigger counter, cleared by any write to its address
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_trig_cnt <= 16'd0;
    end else if (w_wr_acc && (ctrl.ctrl_addr == 16'h0008)) begin
      r_trig_cnt <= 16'd0;
    end else if (w_trig_ok) begin
      r_trig_cnt <= r_trig_cnt + 16'd1;
    end else begin
      r_trig_cnt <= r_trig_cnt;
    end
  end

  assign w_trig_cnt = r_trig_cnt;
`else
  logic w_unused_trig;

  assign w_trig_cnt    = 16'd0;
  assign w_unused_trig = w_trig_ok;
`endif

  // Register read mux
  always_comb begin
    w_rdata = 32'd0;
    case (ctrl.ctrl_addr)
      16'h0000: w_rdata = {24'd0, r_dist};
      16'h0004: w_rdata = {29'd0, r_echo, r_short_err, w_busy};
      16'h0008: w_rdata = {16'd0, w_trig_cnt};
      default:  w_rdata = 32'd0;
    endcase
  end

  // Bus acknowledge, read data capture and dist register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_done <= 1'b0;
      r_rdat <= 32'd0;
      r_dist <= 8'hFF;
    end else begin
      r_done <= w_acc;
      if (w_rd_acc) begin
        r_rdat <= w_rdata;
      end else begin
        r_rdat <= 32'd0;
      end
      if (w_wr_acc && (ctrl.ctrl_addr == 16'h0000)) begin
        r_dist <= ctrl.ctrl_wdat[7:0];
      end else begin
        r_dist <= r_dist;
      end
    end
  end

  assign ctrl.ctrl_done = r_done;
  assign ctrl.ctrl_rdat = r_rdat;
  assign ECHO           = r_echo;

endmodule

// File: tb/tb_icosoc_mod_ping_resp.sv
// Scoreboard bench for icosoc_mod_ping_resp: directed and random triggers checked against a
// timing model of the TRIG/ECHO protocol, with bus reads and ECHO pulses checked by monitors.
module tb_icosoc_mod_ping_resp;
  localparam int CPM  = 7;
  localparam int MINT = 12;
  localparam int DLY  = 30;
  localparam int HOLD = 40;

  typedef struct {
    int rise;
    int width;
  } pulse_t;

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } acc_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic TRIG = 1'b0;
  logic ECHO;
  icosoc_mod_ping_resp_if bus ();

  icosoc_mod_ping_resp #(
    .CLOCK_FREQ_HZ(20000000),
    .CYCLES_PER_CM(CPM),
    .MIN_TRIG_CYCLES(MINT),
    .ECHO_DELAY_CYCLES(DLY),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ctrl(bus),
    .TRIG(TRIG),
    .ECHO(ECHO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  pulse_t echo_q[$];
  acc_t   acc_q[$];

  // model state: edge numbers refer to the state held after that posedge
  int m_dist = 255;
  int m_short = 0;
  int m_cnt = 0;
  int m_lo = 0;
  int m_idle = 0;
  int m_rise = 0;
  int m_fall = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] exp_status(input int c);
    logic busy;
    logic ec;
    busy = (c >= m_lo) && (c < m_idle);
    ec   = (c >= m_rise) && (c < m_fall);
    return {29'd0, ec, (m_short != 0), busy};
  endfunction

  function automatic logic [31:0] exp_trigcnt();
`ifdef PING_RESP_TRIGCNT_EN
    return 32'(m_cnt) & 32'h0000_FFFF;
`else
    return 32'd0;
`endif
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    acc_t e;
    e.is_read = 1'b0;
    e.exp = 32'd0;
    e.name = "write";
    acc_q.push_back(e);
    bus.ctrl_addr = a;
    bus.ctrl_wdat = d;
    bus.ctrl_wr = 4'($urandom_range(1, 15));
    @(negedge clk);
    bus.ctrl_wr = 4'h0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] exp, input string nm);
    acc_t e;
    e.is_read = 1'b1;
    e.exp = exp;
    e.name = nm;
    acc_q.push_back(e);
    bus.ctrl_addr = a;
    bus.ctrl_rd = 1'b1;
    @(negedge clk);
    bus.ctrl_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_status(input string nm);
    bus_read(16'h0004, exp_status(cyc), nm);
  endtask

  task automatic set_dist(input int d);
    bus_write(16'h0000, (32'($urandom) & 32'hFFFF_FF00) | 32'(d));
    m_dist = d;
  endtask

  // TRIG high for w clock edges; trunc>0 means the pulse will be cut by reset after trunc cycles
  task automatic trig(input int w, input int post, input int trunc);
    int r;
    int e0;
    int dl;
    pulse_t p;
    TRIG = 1'b1;
    r = cyc + 1;
    repeat (w) @(negedge clk);
    TRIG = 1'b0;
    e0 = cyc + 1;
    if (r + 1 >= m_idle) begin
      m_lo = r + 2;
      m_rise = 0;
      m_fall = 0;
      if (w < MINT) begin
        m_short = 1;
        m_idle = e0 + 2;
      end else begin
        m_cnt++;
        dl = m_dist;
        if (dl == 255) begin
          m_idle = e0 + DLY + 2 + HOLD;
        end else begin
          m_rise = e0 + DLY + 2;
          m_fall = m_rise + ((dl == 0) ? 1 : dl) * CPM;
          m_idle = m_fall + HOLD;
          p.rise = m_rise;
          p.width = (trunc > 0) ? trunc : (m_fall - m_rise);
          echo_q.push_back(p);
        end
      end
    end
    repeat (post) @(negedge clk);
  endtask

  // bus monitor: every done pulse must match the oldest issued access
  initial begin : mon_bus
    acc_t e;
    forever begin
      @(negedge clk);
      if (bus.ctrl_done === 1'b1) begin
        if (acc_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = acc_q.pop_front();
          if (e.is_read) check(e.name, bus.ctrl_rdat, e.exp);
        end
      end
    end
  end

  // ECHO monitor: rise edge and width of each pulse against the expected queue
  initial begin : mon_echo
    logic prev;
    int rise_at;
    pulse_t p;
    prev = 1'b0;
    rise_at = 0;
    forever begin
      @(negedge clk);
      if (ECHO === 1'b1 && !prev) begin
        rise_at = cyc;
        if (echo_q.size() == 0) check("echo_unexpected_rise", 32'(cyc), 32'd0);
        else check("echo_rise_edge", 32'(cyc), 32'(echo_q[0].rise));
      end else if (ECHO !== 1'b1 && prev) begin
        if (echo_q.size() == 0) begin
          check("echo_unexpected_fall", 32'(cyc), 32'd0);
        end else begin
          p = echo_q.pop_front();
          check("echo_width", 32'(cyc - rise_at), 32'(p.width));
        end
      end
      prev = (ECHO === 1'b1);
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.ctrl_wr = 4'h0;
    bus.ctrl_rd = 1'b0;
    bus.ctrl_addr = 16'h0000;
    bus.ctrl_wdat = 32'd0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_echo", {31'd0, ECHO}, 32'd0);
    check("reset_done", {31'd0, bus.ctrl_done}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    bus_read(16'h0000, 32'h0000_00FF, "reset_dist");
    read_status("reset_status");
    bus_read(16'h0008, 32'd0, "reset_trigcnt");
    bus_read(16'h000C, 32'd0, "unmapped_read");

    // nominal measurement with busy boundary around the end of holdoff
    set_dist(10);
    bus_read(16'h0000, 32'd10, "dist_rb");
    trig(MINT + 8, 3, 0);
    wait_until(m_rise + 3);
    read_status("status_pulse");
    wait_until(m_idle - 2);
    read_status("status_busy_end");
    read_status("status_idle_after");

    // short trigger, clear, and exact minimum width
    wait_until(m_idle + 2);
    trig(MINT - 1, 3, 0);
    read_status("status_short");
    bus_write(16'h0004, 32'h0000_0002);
    m_short = 0;
    read_status("status_short_clr");
    set_dist(2);
    trig(MINT, 3, 0);
    wait_until(m_idle + 2);

    // short set and software clear on the same edge: set wins
    trig(MINT - 2, 2, 0);
    bus_write(16'h0004, 32'h0000_0002);
    read_status("status_set_wins");
    bus_write(16'h0004, 32'h0000_0002);
    m_short = 0;
    read_status("status_cleared");

    // no target, then dist 0 treated as 1 cm
    set_dist(255);
    trig(MINT + 3, 3, 0);
    wait_until(m_idle - 2);
    read_status("status_nt_busy");
    read_status("status_nt_idle");
    set_dist(0);
    trig(MINT + 1, 3, 0);
    wait_until(m_idle + 2);

    // overlap: dist change and TRIG during PULSE affect only the next measurement
    set_dist(5);
    trig(MINT + 5, 3, 0);
    wait_until(m_rise + 10);
    set_dist(3);
    trig(MINT + 15, 3, 0);
    bus_read(16'h0000, 32'd3, "dist_mid");
    wait_until(m_idle + 2);
    trig(MINT + 4, 3, 0);
    bus_read(16'h0008, exp_trigcnt(), "trigcnt");
    wait_until(m_idle + 2);
    bus_write(16'h0008, 32'h1234_5678);
`ifdef PING_RESP_TRIGCNT_EN
    m_cnt = 0;
`endif
    bus_read(16'h0008, exp_trigcnt(), "trigcnt_clr");

    for (int i = 0; i < 30; i++) begin
      int sel;
      int d;
      int gap;
      sel = $urandom_range(0, 7);
      d = (sel == 0) ? 0 : (sel == 1) ? 255 : (sel == 2) ? 1 : $urandom_range(2, 25);
      set_dist(d);
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
      if (gap == 0) wait_until(m_idle + 2);
      else repeat (gap) @(negedge clk);
      read_status("rnd_status_pre");
      trig($urandom_range(MINT - 3, MINT + 8), 3, 0);
      repeat ($urandom_range(0, 60)) @(negedge clk);
      read_status("rnd_status_post");
      if ($urandom_range(0, 3) == 0) begin
        bus_write(16'h0004, 32'h0000_0002);
        m_short = 0;
      end
      if (sel == 3) bus_read(16'h0008, exp_trigcnt(), "rnd_trigcnt");
      bus_read(16'h0000, 32'(m_dist), "rnd_dist");
    end

    // reset in the middle of an echo pulse
    wait_until(m_idle + 2);
    set_dist(10);
    trig(MINT + 2, 3, 20);
    wait_until(m_rise + 19);
    resetn = 1'b0;
    @(negedge clk);
    check("echo_after_reset", {31'd0, ECHO}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    m_dist = 255;
    m_short = 0;
    m_cnt = 0;
    m_lo = 0;
    m_idle = 0;
    m_rise = 0;
    m_fall = 0;
    @(negedge clk);
    bus_read(16'h0000, 32'h0000_00FF, "dist_after_reset");
    read_status("status_after_reset");
    bus_read(16'h0008, 32'd0, "trigcnt_after_reset");
    repeat (DLY + 10 * CPM + HOLD) @(negedge clk);

    check("echo_queue_empty", 32'(echo_q.size()), 32'd0);
    check("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    check("echo_idle_end", {31'd0, ECHO}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
